// File: rtl/main_memory_ctrl.sv
// rtl/main_memory_ctrl.sv - block-granular main memory behind unified_cache with programmable latency
// One request in flight; response held until the cache acknowledges it.
module main_memory_ctrl #(
  parameter int ADDR_WIDTH    = 64,
  parameter int BLOCK_BYTES   = 16,
  parameter int BLOCK_WIDTH   = BLOCK_BYTES * 8,
  parameter int MEM_DEPTH     = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int PKT_WIDTH     = ADDR_WIDTH + BLOCK_WIDTH + 5
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [PKT_WIDTH-1:0] req_packet_in,
  output logic                 req_ack_out,
  output logic [PKT_WIDTH-1:0] resp_packet_out,
  input  logic                 resp_ack_in,
  output logic                 busy_out
);

  localparam int OFF_W     = $clog2(BLOCK_BYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int LAT_MAX   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int DATA_LSB  = ADDR_WIDTH;
  localparam int VALID_BIT = ADDR_WIDTH + BLOCK_WIDTH;
  localparam int WRITE_BIT = VALID_BIT + 1;
  localparam int TYPE_LSB  = VALID_BIT + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             type_q, type_d;
  logic                   wr_q, wr_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [PKT_WIDTH-1:0]   resp_q, resp_d;

  logic [BLOCK_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]       idx;
  logic                   mem_we;

  // Offset bits and bits above the array size are dropped, so addresses alias modulo the array span.
  assign idx    = addr_q[OFF_W +: IDX_W];
  assign mem_we = (state_q == S_BUSY) && (cnt_q == '0) && wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    wr_d    = wr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_packet_in[VALID_BIT]) begin
          type_d  = req_packet_in[TYPE_LSB +: 3];
          wr_d    = req_packet_in[WRITE_BIT];
          data_d  = req_packet_in[DATA_LSB +: BLOCK_WIDTH];
          addr_d  = req_packet_in[ADDR_WIDTH-1:0];
          cnt_d   = req_packet_in[WRITE_BIT] ? CNT_W'(WRITE_LATENCY - 1)
                                             : CNT_W'(READ_LATENCY - 1);
          ack_d   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          // The write lands in the same edge as the response is registered.
          if (wr_q) resp_d = {type_q, 1'b1, 1'b1, {BLOCK_WIDTH{1'b0}}, addr_q};
          else      resp_d = {type_q, 1'b0, 1'b1, mem_q[idx], addr_q};
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ack_in) begin
          resp_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      resp_q  <= resp_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[idx] <= data_q;
  end

  assign req_ack_out     = ack_q;
  assign resp_packet_out = resp_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb/tb_main_memory_ctrl.sv - directed self-checking bench for main_memory_ctrl
// One task per scenario; expected values are hand-computed constants.
module tb_main_memory_ctrl;

  localparam int AW = 64;
  localparam int BW = 128;
  localparam int P  = AW + BW + 5;
  localparam int VB = AW + BW;
  localparam int WB = VB + 1;

  logic         clk_in = 1'b0;
  logic         reset_in = 1'b1;
  logic [P-1:0] req_packet_in = '0;
  logic         req_ack_out;
  logic [P-1:0] resp_packet_out;
  logic         resp_ack_in = 1'b0;
  logic         busy_out;

  int total = 0;
  int bad = 0;

  main_memory_ctrl #(
    .ADDR_WIDTH(AW), .BLOCK_BYTES(16), .BLOCK_WIDTH(BW), .MEM_DEPTH(32),
    .READ_LATENCY(4), .WRITE_LATENCY(2), .PKT_WIDTH(P)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .req_packet_in(req_packet_in),
    .req_ack_out(req_ack_out), .resp_packet_out(resp_packet_out),
    .resp_ack_in(resp_ack_in), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [P-1:0] mk_pkt(input logic [2:0] ty, input logic wr,
                                          input logic [BW-1:0] d, input logic [AW-1:0] a);
    return {ty, wr, 1'b1, d, a};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Issues one request and reports what the DUT did; checking happens in the callers.
  task automatic transact(input logic [2:0] ty, input logic wr, input logic [BW-1:0] d,
                          input logic [AW-1:0] a, input bit do_ack,
                          output logic [P-1:0] resp, output int ack_edges, output logic ack_after,
                          output int lat, output logic [P-1:0] resp_after, output logic busy_after);
    req_packet_in = mk_pkt(ty, wr, d, a);
    ack_edges = 0;
    do begin
      step();
      ack_edges++;
    end while (!req_ack_out && ack_edges < 20);
    req_packet_in = '0;
    lat = 0;
    ack_after = 1'b0;
    while (!resp_packet_out[VB] && lat < 50) begin
      step();
      lat++;
      if (lat == 1) ack_after = req_ack_out;
    end
    resp = resp_packet_out;
    resp_after = resp;
    busy_after = busy_out;
    if (do_ack) begin
      resp_ack_in = 1'b1;
      step();
      resp_ack_in = 1'b0;
      resp_after = resp_packet_out;
      busy_after = busy_out;
    end
  endtask

  task automatic test_reset();
    logic [P-1:0] r, ra;
    int ae, lt;
    logic aa, ba;
    reset_in = 1'b1;
    step();
    step();
    reset_in = 1'b0;
    step();
    total++;
    if (resp_packet_out !== '0) begin bad++; $display("FAIL reset_resp got=%h exp=0", resp_packet_out); end
    total++;
    if (req_ack_out !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", req_ack_out); end
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    for (int i = 0; i < 8; i++) begin
      transact(3'b001, 1'b1, BW'(i), AW'(i * 16), 1'b1, r, ae, aa, lt, ra, ba);
      total++;
      if (lt !== 2 || r[WB] !== 1'b1 || ra !== '0) begin
        bad++;
        $display("FAIL preload_%0d lat=%0d wr=%b after=%h exp lat=2 wr=1 after=0", i, lt, r[WB], ra);
      end
    end
  endtask

  task automatic test_read();
    logic [P-1:0] r, ra;
    int ae, lt;
    logic aa, ba;
    transact(3'b010, 1'b0, '0, 64'h40, 1'b0, r, ae, aa, lt, ra, ba);
    total++;
    if (ae !== 1) begin bad++; $display("FAIL read_ack_edge got=%0d exp=1", ae); end
    total++;
    if (aa !== 1'b0) begin bad++; $display("FAIL read_ack_pulse got=%b exp=0", aa); end
    total++;
    if (lt !== 4) begin bad++; $display("FAIL read_latency got=%0d exp=4", lt); end
    total++;
    if (r !== {3'b010, 1'b0, 1'b1, 128'd4, 64'h40}) begin
      bad++;
      $display("FAIL read_resp got=%h exp=%h", r, {3'b010, 1'b0, 1'b1, 128'd4, 64'h40});
    end
    for (int i = 0; i < 3; i++) step();
    total++;
    if (resp_packet_out !== r || busy_out !== 1'b1) begin
      bad++;
      $display("FAIL read_hold got=%h busy=%b exp=%h busy=1", resp_packet_out, busy_out, r);
    end
    resp_ack_in = 1'b1;
    step();
    resp_ack_in = 1'b0;
    total++;
    if (resp_packet_out !== '0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL read_clear got=%h busy=%b exp=0 busy=0", resp_packet_out, busy_out);
    end
  endtask

  task automatic test_write_read();
    logic [P-1:0] r, ra;
    int ae, lt;
    logic aa, ba;
    transact(3'b001, 1'b1, 128'hDEAD, 64'h50, 1'b1, r, ae, aa, lt, ra, ba);
    total++;
    if (lt !== 2) begin bad++; $display("FAIL write_latency got=%0d exp=2", lt); end
    total++;
    if (r !== {3'b001, 1'b1, 1'b1, 128'd0, 64'h50}) begin
      bad++;
      $display("FAIL write_resp got=%h exp=%h", r, {3'b001, 1'b1, 1'b1, 128'd0, 64'h50});
    end
    transact(3'b010, 1'b0, '0, 64'h50, 1'b1, r, ae, aa, lt, ra, ba);
    total++;
    if (r[VB-1:AW] !== 128'hDEAD) begin bad++; $display("FAIL write_readback got=%h exp=dead", r[VB-1:AW]); end
  endtask

  task automatic test_wrap();
    logic [P-1:0] r, ra;
    int ae, lt;
    logic aa, ba;
    transact(3'b010, 1'b0, '0, 64'h240, 1'b1, r, ae, aa, lt, ra, ba);
    total++;
    if (r[VB-1:AW] !== 128'd4 || r[AW-1:0] !== 64'h240) begin
      bad++;
      $display("FAIL wrap_index data=%h addr=%h exp data=4 addr=240", r[VB-1:AW], r[AW-1:0]);
    end
    transact(3'b010, 1'b0, '0, 64'h4F, 1'b1, r, ae, aa, lt, ra, ba);
    total++;
    if (r[VB-1:AW] !== 128'd4 || r[AW-1:0] !== 64'h4F) begin
      bad++;
      $display("FAIL wrap_offset data=%h addr=%h exp data=4 addr=4f", r[VB-1:AW], r[AW-1:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [P-1:0] r, ra;
    int ae, lt, errs, n;
    logic aa, ba;
    transact(3'b010, 1'b0, '0, 64'h10, 1'b0, r, ae, aa, lt, ra, ba);
    total++;
    if (r[VB-1:AW] !== 128'd1) begin bad++; $display("FAIL bp_first_data got=%h exp=1", r[VB-1:AW]); end
    req_packet_in = mk_pkt(3'b010, 1'b0, '0, 64'h20);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_packet_out !== r || busy_out !== 1'b1 || req_ack_out !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d exp=0", errs); end
    resp_ack_in = 1'b1;
    step();
    resp_ack_in = 1'b0;
    total++;
    if (req_ack_out !== 1'b0 || resp_packet_out !== '0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_release ack=%b resp=%h busy=%b exp ack=0 resp=0 busy=0", req_ack_out, resp_packet_out, busy_out);
    end
    step();
    total++;
    if (req_ack_out !== 1'b1 || busy_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_capture ack=%b busy=%b exp ack=1 busy=1", req_ack_out, busy_out);
    end
    req_packet_in = '0;
    n = 0;
    while (!resp_packet_out[VB] && n < 50) begin step(); n++; end
    total++;
    if (n !== 4 || resp_packet_out[VB-1:AW] !== 128'd2) begin
      bad++;
      $display("FAIL bp_second lat=%0d data=%h exp lat=4 data=2", n, resp_packet_out[VB-1:AW]);
    end
    resp_ack_in = 1'b1;
    step();
    resp_ack_in = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [P-1:0] r, ra;
    int ae, lt;
    logic aa, ba;
    req_packet_in = mk_pkt(3'b001, 1'b1, 128'hBEEF, 64'h60);
    step();
    req_packet_in = '0;
    total++;
    if (req_ack_out !== 1'b1) begin bad++; $display("FAIL rb_ack got=%b exp=1", req_ack_out); end
    step();
    reset_in = 1'b1;
    #1;
    total++;
    if (resp_packet_out !== '0 || req_ack_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL rb_async resp=%h ack=%b busy=%b exp all 0", resp_packet_out, req_ack_out, busy_out);
    end
    step();
    reset_in = 1'b0;
    step();
    transact(3'b010, 1'b0, '0, 64'h60, 1'b1, r, ae, aa, lt, ra, ba);
    total++;
    if (r[VB-1:AW] !== 128'd6) begin bad++; $display("FAIL rb_no_commit got=%h exp=6", r[VB-1:AW]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
